// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces the
// row response, and offers one key code per press through a valid/ready port.
module keypad_scan_ctrl #(
  parameter int SETTLE = 270,
  parameter int STABLE = 270_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] code,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       overrun,
  input  logic       clr_ovr,
  output logic       key_down
);

  localparam int CW = ($clog2(STABLE + 1) > 20) ? $clog2(STABLE + 1) : 20;

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_SAMPLE,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      ci_q, ci_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      rlat_q, rlat_d;
  logic [3:0]      code_q, code_d;
  logic            code_valid_q, code_valid_d;
  logic            overrun_q, overrun_d;
  logic [3:0]      s1_q, rs_q;

  logic [3:0]      rlat_low;
  logic            single_key;
  logic [1:0]      row_idx;

  // Rows idle high (pull-ups), so the synchronizer resets to "no key".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 4'b1111;
      rs_q <= 4'b1111;
    end else begin
      s1_q <= row;
      rs_q <= s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_SETTLE;
      ci_q         <= 2'd0;
      cnt_q        <= '0;
      rlat_q       <= 4'b1111;
      code_q       <= 4'd0;
      code_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ci_q         <= ci_d;
      cnt_q        <= cnt_d;
      rlat_q       <= rlat_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  // A single pressed key pulls exactly one row low; more means ghosting.
  always_comb begin
    rlat_low   = ~rlat_q;
    single_key = (rlat_low != 4'd0) && ((rlat_low & (rlat_low - 4'd1)) == 4'd0);
    row_idx    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!rlat_q[i]) row_idx = 2'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    ci_d         = ci_q;
    cnt_d        = cnt_q;
    rlat_d       = rlat_q;
    code_d       = code_q;
    code_valid_d = code_valid_q && !code_ready;
    overrun_d    = overrun_q && !clr_ovr;

    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_SAMPLE: begin
        cnt_d = '0;
        if (rs_q == 4'b1111) begin
          ci_d    = ci_q + 2'd1;
          state_d = ST_SETTLE;
        end else begin
          rlat_d  = rs_q;
          state_d = ST_DEBOUNCE;
        end
      end

      ST_DEBOUNCE: begin
        if (rs_q != rlat_q) begin
          ci_d    = ci_q + 2'd1;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else if (cnt_q == CW'(STABLE - 1)) begin
          cnt_d   = '0;
          state_d = ST_EMIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_EMIT: begin
        // Offer may reuse a slot being drained in this same cycle.
        if (single_key) begin
          if (!code_valid_q || code_ready) begin
            code_d       = {row_idx, ci_q};
            code_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
        cnt_d   = '0;
        state_d = ST_RELEASE;
      end

      ST_RELEASE: begin
        if (rs_q != 4'b1111) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(STABLE - 1)) begin
          cnt_d   = '0;
          ci_d    = ci_q + 2'd1;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign col        = ~(4'b0001 << ci_q);
  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign overrun    = overrun_q;
  assign key_down   = (state_q == ST_DEBOUNCE) || (state_q == ST_EMIT) ||
                      (state_q == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a behavioural 4x4 key matrix drives the rows,
// and accepted codes are compared with the keys that were pressed.
module tb_keypad_scan_ctrl;

  localparam int SETTLE = 4;
  localparam int STABLE = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  code;
  logic        code_valid;
  logic        code_ready = 1'b0;
  logic        overrun;
  logic        clr_ovr = 1'b0;
  logic        key_down;

  logic [15:0] pressed = 16'd0;

  int          total = 0;
  int          bad = 0;
  int          acc_cnt = 0;
  int          cv_rises = 0;
  logic [3:0]  last_code = 4'hx;
  logic        prev_hold = 1'b0;
  logic        prev_cv = 1'b0;
  logic [3:0]  prev_code = 4'd0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.SETTLE(SETTLE), .STABLE(STABLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .row        (row),
    .col        (col),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr),
    .key_down   (key_down)
  );

  // Key k sits at row k/4, column k%4 and shorts that row to a low column.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Consumer-side monitor: records handshakes, checks code holds while waiting.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (prev_hold) check("code_stable", code, prev_code);
      if (code_valid && !prev_cv) cv_rises++;
      if (code_valid && code_ready) begin
        acc_cnt++;
        last_code = code;
        $display("accept code=%0d at %0t", code, $time);
      end
      prev_hold = code_valid && !code_ready;
      prev_cv   = code_valid;
      prev_code = code;
    end else begin
      prev_hold = 1'b0;
      prev_cv   = 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_acc(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && acc_cnt < n; i++) tick();
    check(tag, acc_cnt, n);
  endtask

  task automatic wait_kd(input logic lvl, input int budget, input string tag);
    for (int i = 0; i < budget && key_down !== lvl; i++) tick();
    check(tag, key_down, lvl);
  endtask

  task automatic press_get(input int k, input string tag);
    int base;
    base    = acc_cnt;
    pressed = 16'd1 << k;
    wait_acc(base + 1, 200, {tag, "_acc"});
    check({tag, "_code"}, last_code, k);
  endtask

  initial begin
    logic [3:0] seen[$];
    logic [3:0] c0;
    int run, moves, base, n, k;
    bit first;

    // Reset values appear without any clock edge.
    #3 rst = 1'b0;
    #1;
    check("rst_col", col, 4'b1110);
    check("rst_cv", code_valid, 0);
    check("rst_code", code, 0);
    check("rst_ovr", overrun, 0);
    check("rst_kd", key_down, 0);
    tick(2);
    rst = 1'b1;

    // Idle scan: each column held SETTLE+1 cycles, rotating upward.
    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      seen.push_back(col);
    end
    check("idle_col0", seen[0], 4'b1110);
    run = 1; moves = 0; first = 1'b1;
    for (int i = 1; i < seen.size(); i++) begin
      if (seen[i] == seen[i-1]) begin
        run++;
      end else begin
        c0 = seen[i-1];
        check("idle_rot", seen[i], {c0[2:0], c0[3]});
        if (!first) check("idle_run", run, SETTLE + 1);
        first = 1'b0;
        run = 1;
        moves++;
      end
    end
    check("idle_moves", moves, 8);
    check("idle_no_cv", cv_rises, 0);
    tick();

    // Key 6 (row1/col2): one code, one-cycle valid, timed release.
    code_ready = 1'b1;
    press_get(6, "k6");
    check("k6_cv_pulse", code_valid, 0);
    base = acc_cnt;
    tick($urandom_range(5, 20));
    check("k6_single", acc_cnt, base);
    check("k6_kd_held", key_down, 1);
    pressed = 16'd0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (key_down) n++;
      else break;
    end
    check("k6_release_len", n, 2 + STABLE);
    tick();

    // Contact chatter on key 6, then a steady press.
    base = acc_cnt;
    for (int i = 0; i < 21; i++) begin
      pressed = ((i / 3) % 2 == 0) ? 16'd1 << 6 : 16'd0;
      tick();
    end
    check("chat_quiet", acc_cnt, base);
    press_get(6, "chat");
    tick(20);
    check("chat_one", acc_cnt, base + 1);
    pressed = 16'd0;
    wait_kd(1'b0, 100, "chat_rel");

    // Press shorter than the debounce window is never accepted.
    base = acc_cnt;
    pressed = 16'd1 << 3;
    tick(7);
    pressed = 16'd0;
    tick(40);
    check("short_press", acc_cnt, base);

    // Random single keys with random hold times.
    for (int it = 0; it < 8; it++) begin
      k = $urandom_range(0, 15);
      base = acc_cnt;
      press_get(k, "rnd");
      tick($urandom_range(0, 30));
      check("rnd_single", acc_cnt, base + 1);
      pressed = 16'd0;
      wait_kd(1'b0, 100, "rnd_rel");
      tick($urandom_range(0, 10));
    end

    // Consumer stalled: second key is dropped and flagged.
    code_ready = 1'b0;
    base = acc_cnt;
    pressed = 16'd1 << 0;
    for (int i = 0; i < 200 && !code_valid; i++) tick();
    check("ovr_cv0", code_valid, 1);
    check("ovr_code0", code, 0);
    tick(5);
    pressed = 16'd0;
    wait_kd(1'b0, 100, "ovr_rel0");
    pressed = 16'd1 << 5;
    for (int i = 0; i < 200 && !overrun; i++) tick();
    check("ovr_set", overrun, 1);
    check("ovr_code_kept", code, 0);
    check("ovr_cv_kept", code_valid, 1);
    pressed = 16'd0;
    wait_kd(1'b0, 100, "ovr_rel5");
    tick(5);
    check("ovr_sticky", overrun, 1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("ovr_clr", overrun, 0);
    code_ready = 1'b1;
    wait_acc(base + 1, 10, "ovr_drain");
    check("ovr_drain_code", last_code, 0);
    tick(30);
    check("ovr_no_k5", acc_cnt, base + 1);

    // Ghosting: rows 0 and 3 on column 1 produce nothing.
    base = acc_cnt;
    pressed = (16'd1 << 1) | (16'd1 << 13);
    wait_kd(1'b1, 100, "ghost_kd");
    tick(40);
    check("ghost_no_code", acc_cnt, base);
    check("ghost_no_ovr", overrun, 0);
    pressed = 16'd0;
    wait_kd(1'b0, 100, "ghost_rel");
    c0 = col;
    for (int i = 0; i < 20 && col == c0; i++) tick();
    check("ghost_rescan", col != c0, 1);

    // Reset during debounce of key 9 discards it.
    base = acc_cnt;
    pressed = 16'd1 << 9;
    wait_kd(1'b1, 100, "rst9_kd");
    tick(2);
    rst = 1'b0;
    #1;
    check("rst9_col", col, 4'b1110);
    check("rst9_kd", key_down, 0);
    check("rst9_cv", code_valid, 0);
    check("rst9_code", code, 0);
    check("rst9_ovr", overrun, 0);
    pressed = 16'd0;
    tick(3);
    rst = 1'b1;
    tick(60);
    check("rst9_no_code", acc_cnt, base);
    press_get(9, "k9_fresh");
    pressed = 16'd0;
    wait_kd(1'b0, 100, "k9_rel");
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
